// File: rtl/card_pkg.sv
// card_pkg: shared card codes, width default and baccarat scoring helpers.
package card_pkg;
  localparam int CARD_W = 4;
  localparam logic [3:0] CARD_EMPTY = 4'd0;
  localparam logic [3:0] CARD_ACE = 4'd1;
  localparam logic [3:0] CARD_KING = 4'd13;
  function automatic logic [3:0] card_value(input logic [3:0] c);
    return (c >= CARD_ACE && c <= 4'd9) ? c : 4'd0;
  endfunction
  function automatic logic [3:0] add_mod10(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 5'd10) ? 4'(s - 5'd10) : s[3:0];
  endfunction
endpackage

// File: rtl/hand_slot_bank.sv
// hand_slot_bank: one hand's slots, count, score and natural flag; NATURAL_DETECT_EN enables natural detection.
module hand_slot_bank import card_pkg::*; #(
  parameter int NCARDS = 3,
  parameter int CARD_W = card_pkg::CARD_W,
  parameter int CW = $clog2(NCARDS + 1)
) (
  input  logic                     slow_clock,
  input  logic                     resetb,
  input  logic                     clear,
  input  logic                     wr,
  input  logic [CARD_W-1:0]        card,
  output logic [NCARDS*CARD_W-1:0] slots,
  output logic [CW-1:0]            count,
  output logic [3:0]               score,
  output logic                     full,
  output logic                     natural
);
  logic [3:0] nxt_score;
  logic       nat_set;
  assign nxt_score = add_mod10(score, card_value(card[3:0]));
  assign full = count == CW'(NCARDS);
`ifdef NATURAL_DETECT_EN
  assign nat_set = count == CW'(1) && nxt_score >= 4'd8;
`else
  assign nat_set = 1'b0;
`endif
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      slots <= '0;
      count <= '0;
      score <= '0;
      natural <= 1'b0;
    end else if (clear) begin
      slots <= '0;
      count <= '0;
      score <= '0;
      natural <= 1'b0;
    end else if (wr) begin
      slots[count*CARD_W +: CARD_W] <= card;
      count <= count + CW'(1);
      score <= nxt_score;
      natural <= natural | nat_set;
    end
  end
endmodule

// File: rtl/card_hand_bank.sv
// card_hand_bank: NHANDS-hand card store with valid/ready dealing and running baccarat scores.
// NATURAL_DETECT_EN enables sticky natural flags that lock a hand against further deals.
module card_hand_bank import card_pkg::*; #(
  parameter int NHANDS = 2,
  parameter int NCARDS = 3,
  parameter int CARD_W = card_pkg::CARD_W,
  parameter int HW = (NHANDS > 1) ? $clog2(NHANDS) : 1,
  parameter int CW = $clog2(NCARDS + 1)
) (
  input  logic                            slow_clock,
  input  logic                            resetb,
  input  logic [CARD_W-1:0]               card_in,
  input  logic                            deal_valid,
  input  logic [HW-1:0]                   deal_hand,
  output logic                            deal_ready,
  input  logic                            clear,
  output logic                            deal_err,
  output logic [NHANDS*NCARDS*CARD_W-1:0] hand_cards,
  output logic [NHANDS*CW-1:0]            card_count,
  output logic [NHANDS*4-1:0]             score,
  output logic [NHANDS-1:0]               hand_full,
  output logic [NHANDS-1:0]               natural
);
  logic [NHANDS-1:0] sel;
  logic              card_ok, accept;
  assign card_ok = card_in >= CARD_W'(CARD_ACE) && card_in <= CARD_W'(CARD_KING);
  assign deal_ready = resetb && !clear && |sel && !(|(sel & (hand_full | natural)));
  assign accept = deal_valid && deal_ready && card_ok;
  for (genvar h = 0; h < NHANDS; h++) begin : g_hand
    assign sel[h] = deal_hand == HW'(h);
    hand_slot_bank #(.NCARDS(NCARDS), .CARD_W(CARD_W), .CW(CW)) u_hand (
      .slow_clock(slow_clock),
      .resetb(resetb),
      .clear(clear),
      .wr(accept && sel[h]),
      .card(card_in),
      .slots(hand_cards[h*NCARDS*CARD_W +: NCARDS*CARD_W]),
      .count(card_count[h*CW +: CW]),
      .score(score[h*4 +: 4]),
      .full(hand_full[h]),
      .natural(natural[h])
    );
  end
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) deal_err <= 1'b0;
    else deal_err <= deal_valid && !clear && !accept;
  end
endmodule

// File: tb/tb_card_hand_bank.sv
// tb_card_hand_bank: directed and random dealing against an array-based hand model.
module tb_card_hand_bank;
  localparam int NH = 2, NC = 3, HW = 1, CW = 2;
`ifdef NATURAL_DETECT_EN
  localparam bit NAT = 1'b1;
`else
  localparam bit NAT = 1'b0;
`endif
  logic slow_clock = 1'b0, resetb = 1'b0;
  logic [3:0] card_in = '0;
  logic deal_valid = 1'b0, clear = 1'b0;
  logic [HW-1:0] deal_hand = '0;
  logic deal_ready, deal_err;
  logic [NH*NC*4-1:0] hand_cards;
  logic [NH*CW-1:0] card_count;
  logic [NH*4-1:0] score;
  logic [NH-1:0] hand_full, natural;
  int total = 0, bad = 0;
  int mcards[NH][NC];
  int mcnt[NH];
  int msum[NH];
  bit mnat[NH];

  card_hand_bank #(.NHANDS(NH), .NCARDS(NC)) dut (
    .slow_clock(slow_clock), .resetb(resetb), .card_in(card_in), .deal_valid(deal_valid),
    .deal_hand(deal_hand), .deal_ready(deal_ready), .clear(clear), .deal_err(deal_err),
    .hand_cards(hand_cards), .card_count(card_count), .score(score),
    .hand_full(hand_full), .natural(natural)
  );

  always #5 slow_clock = ~slow_clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int h = 0; h < NH; h++) begin
      for (int s = 0; s < NC; s++) mcards[h][s] = 0;
      mcnt[h] = 0;
      msum[h] = 0;
      mnat[h] = 1'b0;
    end
  endtask

  task automatic check_all(input bit exp_err);
    logic [NH*NC*4-1:0] ec;
    logic [NH*CW-1:0] en;
    logic [NH*4-1:0] es;
    logic [NH-1:0] ef, ea;
    for (int h = 0; h < NH; h++) begin
      for (int s = 0; s < NC; s++) ec[(h*NC+s)*4 +: 4] = 4'(mcards[h][s]);
      en[h*CW +: CW] = CW'(mcnt[h]);
      es[h*4 +: 4] = 4'(msum[h] % 10);
      ef[h] = mcnt[h] == NC;
      ea[h] = mnat[h];
    end
    check("hand_cards", 32'(hand_cards), 32'(ec));
    check("card_count", 32'(card_count), 32'(en));
    check("score", 32'(score), 32'(es));
    check("hand_full", 32'(hand_full), 32'(ef));
    check("natural", 32'(natural), 32'(ea));
    check("deal_err", 32'(deal_err), 32'(exp_err));
  endtask

  task automatic cyc(input bit v, input int hnd, input int c, input bit clr);
    bit rdy, acc, err;
    deal_valid = v;
    deal_hand = HW'(hnd);
    card_in = 4'(c);
    clear = clr;
    #1;
    rdy = !clr && hnd < NH && mcnt[hnd] < NC && !mnat[hnd];
    check("deal_ready", 32'(deal_ready), 32'(rdy));
    acc = v && rdy && c >= 1 && c <= 13;
    err = v && !clr && !acc;
    @(posedge slow_clock);
    #1;
    if (clr) model_clear();
    else if (acc) begin
      mcards[hnd][mcnt[hnd]] = c;
      mcnt[hnd]++;
      msum[hnd] += (c <= 9) ? c : 0;
      if (NAT && mcnt[hnd] == 2 && msum[hnd] % 10 >= 8) mnat[hnd] = 1'b1;
    end
    deal_valid = 1'b0;
    clear = 1'b0;
    check_all(err);
  endtask

  initial begin
    model_clear();
    #12;
    check("ready_in_reset", 32'(deal_ready), 32'd0);
    check_all(1'b0);
    @(negedge slow_clock);
    resetb = 1'b1;
    cyc(1, 0, 7, 0);
    cyc(1, 0, 5, 0);
    check("tp1_slots", 32'(hand_cards[7:0]), 32'h57);
    check("tp1_score", 32'(score[3:0]), 32'd2);
    check("tp1_hand1", 32'(hand_cards[23:12]), 32'd0);
    cyc(1, 1, 13, 0);
    cyc(1, 1, 12, 0);
    cyc(1, 1, 9, 0);
    check("tp2_score", 32'(score[7:4]), 32'd9);
    check("tp2_full", 32'(hand_full[1]), 32'd1);
    cyc(1, 1, 2, 0);
    check("tp2_err", 32'(deal_err), 32'd1);
    cyc(0, 0, 0, 0);
    check("tp2_err_one", 32'(deal_err), 32'd0);
    cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 0);
    check("tp3_err0", 32'(deal_err), 32'd1);
    cyc(1, 0, 14, 0);
    check("tp3_err14", 32'(deal_err), 32'd1);
    check("tp3_count", 32'(card_count), 32'd0);
    cyc(1, 0, 3, 0);
    cyc(1, 1, 4, 0);
    cyc(1, 0, 6, 1);
    check("tp4_clear", 32'(hand_cards), 32'd0);
    check("tp4_noerr", 32'(deal_err), 32'd0);
    cyc(1, 0, 2, 0);
    check("tp4_slot0", 32'(hand_cards[3:0]), 32'd2);
    cyc(0, 0, 0, 1);
    cyc(1, 0, 4, 0);
    cyc(1, 0, 5, 0);
    check("tp5_score", 32'(score[3:0]), 32'd9);
    check("tp5_natural", 32'(natural[0]), 32'(NAT));
    cyc(1, 0, 1, 0);
    check("tp5_third", 32'(card_count[1:0]), NAT ? 32'd2 : 32'd3);
    cyc(0, 0, 0, 1);
    cyc(1, 0, 8, 0);
    #2;
    resetb = 1'b0;
    #1;
    model_clear();
    check("tp6_ready", 32'(deal_ready), 32'd0);
    check_all(1'b0);
    @(negedge slow_clock);
    resetb = 1'b1;
    cyc(1, 0, 3, 0);
    check("tp6_slot0", 32'(hand_cards[3:0]), 32'd3);
    check("tp6_score", 32'(score[3:0]), 32'd3);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 9) < 8, $urandom_range(0, NH - 1), $urandom_range(0, 15),
          $urandom_range(0, 19) == 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
